signed_mul8_seq: RTL and testbench
==================================

Name: signed_mul8_seq

Overview:
- Sequential signed 8x8 multiplier front/back end for the gate-level signed calculator.
- Takes two's-complement 8-bit operands through a valid/ready handshake and converts them to sign plus magnitude.
- Drives the 4x4 unsigned array multiplier stage (9-bit product, active-high gating input) with four nibble pairs over four cycles, then accumulates the shifted partial products.
- Restores the sign and presents a 16-bit signed product downstream.

Parameters:
- REG_SIGN, 1: 1 = dedicated SIGN cycle before output (latency 5); 0 = sign applied on the PP3 edge (latency 4).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  8  signed multiplicand
- b  input  8  signed multiplier
- mul_en  output  1  drives the 4x4 multiplier's active-high gating input
- pp_a  output  4  nibble to 4x4 multiplier operand a
- pp_b  output  4  nibble to 4x4 multiplier operand b
- pp_in  input  9  combinational product from 4x4 multiplier; bit 8 ignored
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- product  output  16  signed result a*b
- zero  output  1  product == 0, valid with out_valid

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, product=0, zero=0, mul_en=0, pp_a=0, pp_b=0, accumulator=0.
- States: IDLE, PP0, PP1, PP2, PP3, SIGN (only if REG_SIGN=1), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: capture sgn=a[7]^b[7], ma=|a|, mb=|b| as 8-bit unsigned (|-128|=0x80), clear the accumulator, go to PP0.
- in_ready=0 in every state except IDLE.
- No acceptance in DONE, even in the same cycle out_ready is high.
- PPk cycles:
  - mul_en=1; pp_a/pp_b are driven combinationally from state.
  - PP0: ma[3:0]*mb[3:0], shift 0.
  - PP1: ma[7:4]*mb[3:0], shift 4.
  - PP2: ma[3:0]*mb[7:4], shift 4.
  - PP3: ma[7:4]*mb[7:4], shift 8.
  - At each edge: acc <= acc + (pp_in[7:0] << shift), 16-bit unsigned. The maximum 128*128=16384 never overflows.
  - Outside PPk: mul_en=0, pp_a=pp_b=0.
- SIGN: product <= sgn ? (~acc+1) : acc; zero <= (acc==0). Then go to DONE.
- Zero rule: a zero magnitude gives product 0x0000 regardless of sgn (negating 0 yields 0).
- With REG_SIGN=0, the PP3 edge writes the final accumulated value through the sign logic directly into product/zero and goes to DONE.
- DONE:
  - out_valid=1; product and zero are held stable.
  - On out_ready: out_valid drops at that edge and the state returns to IDLE.
  - Next accept is possible on the following edge.
- Latency: out_valid rises 5 edges after the accept edge (4 when REG_SIGN=0).
- Throughput: one product per 7 cycles with out_ready held high (6 when REG_SIGN=0).
- Operands a and b are don't-care after the accept edge; changing them mid-operation has no effect.
- pp_in[8] nonzero is ignored, never propagated.
- Reset mid-operation (any state): immediate return to reset values. The partial result is discarded, with no out_valid pulse.
- in_valid without in_ready: no effect; the source must hold its data.

Test Plan:
- a=7 (0x07), b=-3 (0xFD), out_ready=1 -> pp sequence (7,3),(0,3),(7,0),(0,0); out_valid 5 edges after accept; product=0xFFEB (-21), zero=0.
- a=-128 (0x80), b=-128 (0x80) -> product=0x4000 (16384); a=0x80, b=0x7F -> product=0xC080 (-16256).
- a=0x00, b=0xFB (-5) -> product=0x0000, zero=1, no negative zero.
- a=-1, b=-1 with out_ready low for 3 cycles after out_valid -> product=0x0001 held stable, in_ready=0 throughout; out_ready high -> out_valid drops and in_ready=1 on the next cycle.
- Back-to-back: 12*10 then -6*9 with in_valid held high -> 0x0078 then 0xFFCA (-54); second accept occurs only after the first handshake completes.
- Assert rst asynchronously during PP2 of 100*100 -> outputs immediately at reset values, mul_en=0; after release, 3*4 -> product=0x000C.
- REG_SIGN=0 build, 7*-3 -> product=0xFFEB with 4-edge latency.

Source files
------------

// File: rtl/signed_mul8_seq.sv
// Sequential signed 8x8 multiplier built around an external 4x4 unsigned array multiplier.
// Operands are taken as sign + magnitude, the four nibble partial products are requested from
// the 4x4 stage over four cycles and accumulated, then the sign is restored.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (a, b two's-complement 8-bit)
//   mul_en            active-high gating input of the 4x4 multiplier
//   pp_a/pp_b         nibble operands to the 4x4 multiplier
//   pp_in             9-bit combinational product from the 4x4 multiplier (bit 8 unused)
//   out_valid/out_ready result handshake
//   product, zero     16-bit signed result and product==0 flag, valid with out_valid
//
// REG_SIGN = 1 adds a dedicated sign cycle (latency 5); 0 applies the sign on the PP3 edge
// (latency 4).

module signed_mul8_seq #(
    parameter bit REG_SIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        mul_en,
    output logic [3:0]  pp_a,
    output logic [3:0]  pp_b,
    input  logic [8:0]  pp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        zero
);

    typedef enum logic [2:0] {
        StIdle,
        StPp0,
        StPp1,
        StPp2,
        StPp3,
        StSign,
        StDone
    } state_t;

    state_t      state_q, state_d;
    logic        sgn_q;
    logic [7:0]  ma_q, mb_q;
    logic [15:0] acc_q;
    logic [15:0] product_q;
    logic        zero_q;

    logic [15:0] pp_shifted;
    logic [15:0] acc_sum;
    logic [15:0] sign_src;
    logic [15:0] signed_val;
    logic [7:0]  abs_a, abs_b;
    logic        accept;
    logic        sign_load;

    // The 4x4 product never exceeds 225, so bit 8 carries no information.
    logic unused_pp_msb;
    assign unused_pp_msb = pp_in[8];

    // |-128| wraps to 0x80, which is the correct unsigned magnitude.
    assign abs_a = a[7] ? (~a + 8'd1) : a;
    assign abs_b = b[7] ? (~b + 8'd1) : b;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign product   = product_q;
    assign zero      = zero_q;

    always_comb begin
        state_d    = state_q;
        mul_en     = 1'b0;
        pp_a       = 4'h0;
        pp_b       = 4'h0;
        pp_shifted = 16'h0000;
        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = StPp0;
            end
            StPp0: begin
                mul_en     = 1'b1;
                pp_a       = ma_q[3:0];
                pp_b       = mb_q[3:0];
                pp_shifted = {8'h00, pp_in[7:0]};
                state_d    = StPp1;
            end
            StPp1: begin
                mul_en     = 1'b1;
                pp_a       = ma_q[7:4];
                pp_b       = mb_q[3:0];
                pp_shifted = {4'h0, pp_in[7:0], 4'h0};
                state_d    = StPp2;
            end
            StPp2: begin
                mul_en     = 1'b1;
                pp_a       = ma_q[3:0];
                pp_b       = mb_q[7:4];
                pp_shifted = {4'h0, pp_in[7:0], 4'h0};
                state_d    = StPp3;
            end
            StPp3: begin
                mul_en     = 1'b1;
                pp_a       = ma_q[7:4];
                pp_b       = mb_q[7:4];
                pp_shifted = {pp_in[7:0], 8'h00};
                state_d    = REG_SIGN ? StSign : StDone;
            end
            StSign: begin
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign acc_sum = acc_q + pp_shifted;

    // Without the sign cycle the PP3 sum goes straight through the sign logic.
    assign sign_src   = REG_SIGN ? acc_q : acc_sum;
    assign signed_val = sgn_q ? (~sign_src + 16'd1) : sign_src;
    assign sign_load  = REG_SIGN ? (state_q == StSign) : (state_q == StPp3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sgn_q     <= 1'b0;
            ma_q      <= 8'h00;
            mb_q      <= 8'h00;
            acc_q     <= 16'h0000;
            product_q <= 16'h0000;
            zero_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sgn_q <= a[7] ^ b[7];
                ma_q  <= abs_a;
                mb_q  <= abs_b;
                acc_q <= 16'h0000;
            end else if (mul_en) begin
                acc_q <= acc_sum;
            end
            if (sign_load) begin
                product_q <= signed_val;
                zero_q    <= (sign_src == 16'h0000);
            end
        end
    end

endmodule

// File: tb/tb_signed_mul8_seq.sv
// Directed testbench for signed_mul8_seq: one instance with the sign cycle, one without.
// A behavioural 4x4 multiplier drives pp_in with bit 8 forced high to show it is ignored.

module tb_signed_mul8_seq;

    logic        clk;
    logic        rst;
    logic [7:0]  a, b;

    logic        in_valid, in_ready, mul_en, out_valid, out_ready, zero;
    logic [3:0]  pp_a, pp_b;
    logic [8:0]  pp_in;
    logic [15:0] product;
    logic [7:0]  mprod;

    logic        in_valid2, in_ready2, mul_en2, out_valid2, out_ready2, zero2;
    logic [3:0]  pp_a2, pp_b2;
    logic [8:0]  pp_in2;
    logic [15:0] product2;
    logic [7:0]  mprod2;

    int checks;
    int errors;

    logic [3:0] pa_log [4];
    logic [3:0] pb_log [4];
    int         npp;

    assign mprod  = pp_a * pp_b;
    assign pp_in  = mul_en ? {1'b1, mprod} : 9'h1AA;
    assign mprod2 = pp_a2 * pp_b2;
    assign pp_in2 = mul_en2 ? {1'b1, mprod2} : 9'h155;

    signed_mul8_seq #(.REG_SIGN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mul_en    (mul_en),
        .pp_a      (pp_a),
        .pp_b      (pp_b),
        .pp_in     (pp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .zero      (zero)
    );

    signed_mul8_seq #(.REG_SIGN(1'b0)) dut_nosign (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .mul_en    (mul_en2),
        .pp_a      (pp_a2),
        .pp_b      (pp_b2),
        .pp_in     (pp_in2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .product   (product2),
        .zero      (zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Submit one operation to the main instance; returns edges from accept to out_valid.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, output int lat,
                          output logic [15:0] p, output logic z);
        int n;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'h5A;
        b = 8'hA5;
        npp = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (mul_en && npp < 4) begin
                pa_log[npp] = pp_a;
                pb_log[npp] = pp_b;
                npp++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        p = product;
        z = zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        out_ready2 = 1'b1;
        a = 8'h00;
        b = 8'h00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (product !== 16'h0000) begin errors++;
            $display("FAIL reset_product got %h want 0000", product); end
        checks++; if (zero !== 1'b0) begin errors++;
            $display("FAIL reset_zero got %b want 0", zero); end
        checks++; if (mul_en !== 1'b0) begin errors++;
            $display("FAIL reset_mul_en got %b want 0", mul_en); end
        checks++; if (pp_a !== 4'h0 || pp_b !== 4'h0) begin errors++;
            $display("FAIL reset_pp got %h/%h want 0/0", pp_a, pp_b); end
        checks++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++;
            $display("FAIL reset_nosign got ov=%b ir=%b want 0/1", out_valid2, in_ready2); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] p;
        logic z;
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];
        exp_a = '{4'd7, 4'd0, 4'd7, 4'd0};
        exp_b = '{4'd3, 4'd3, 4'd0, 4'd0};
        run_op(8'h07, 8'hFD, lat, p, z);
        checks++; if (lat !== 5) begin errors++;
            $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (p !== 16'hFFEB) begin errors++;
            $display("FAIL basic_product got %h want ffeb", p); end
        checks++; if (z !== 1'b0) begin errors++;
            $display("FAIL basic_zero got %b want 0", z); end
        checks++; if (npp !== 4) begin errors++;
            $display("FAIL basic_pp_count got %0d want 4", npp); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pa_log[i] !== exp_a[i] || pb_log[i] !== exp_b[i]) begin errors++;
                $display("FAIL basic_pp%0d got (%0d,%0d) want (%0d,%0d)", i, pa_log[i],
                         pb_log[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int lat;
        logic [15:0] p;
        logic z;
        run_op(8'h80, 8'h80, lat, p, z);
        checks++; if (p !== 16'h4000) begin errors++;
            $display("FAIL ext_m128_m128 got %h want 4000", p); end
        run_op(8'h80, 8'h7F, lat, p, z);
        checks++; if (p !== 16'hC080) begin errors++;
            $display("FAIL ext_m128_127 got %h want c080", p); end
        checks++; if (z !== 1'b0) begin errors++;
            $display("FAIL ext_zero got %b want 0", z); end
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] p;
        logic z;
        run_op(8'h00, 8'hFB, lat, p, z);
        checks++; if (p !== 16'h0000) begin errors++;
            $display("FAIL zero_product got %h want 0000", p); end
        checks++; if (z !== 1'b1) begin errors++;
            $display("FAIL zero_flag got %b want 1", z); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] p;
        logic z;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run_op(8'hFF, 8'hFF, lat, p, z);
        checks++; if (lat !== 5 || p !== 16'h0001) begin errors++;
            $display("FAIL bp_result got lat=%0d p=%h want 5/0001", lat, p); end
        // Offer new operands while stalled; they must not be taken.
        in_valid = 1'b1;
        a = 8'h05;
        b = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || product !== 16'h0001 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b p=%h ir=%b want 1/0001/0", i, out_valid,
                         product, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3;
        logic [15:0] p1, p2;
        logic prev_ready;
        @(negedge clk);
        a = 8'd12;
        b = 8'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hFA;
        b = 8'd9;
        t1 = -1; t2 = -1; t3 = -1;
        p1 = 16'hxxxx; p2 = 16'hxxxx;
        prev_ready = in_ready;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            if (out_valid && t1 < 0) begin t1 = t; p1 = product; end
            else if (out_valid && t2 >= 0 && t3 < 0) begin t3 = t; p2 = product; end
            if (prev_ready && mul_en && t2 < 0) begin
                t2 = t;
                in_valid = 1'b0;
                a = 8'h33;
            end
            prev_ready = in_ready;
        end
        in_valid = 1'b0;
        checks++; if (t1 !== 5 || p1 !== 16'h0078) begin errors++;
            $display("FAIL b2b_first got t=%0d p=%h want 5/0078", t1, p1); end
        checks++; if (t2 !== 7) begin errors++;
            $display("FAIL b2b_second_accept got t=%0d want 7", t2); end
        checks++; if (t3 !== 12 || p2 !== 16'hFFCA) begin errors++;
            $display("FAIL b2b_second got t=%0d p=%h want 12/ffca", t3, p2); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] p;
        logic z;
        @(negedge clk);
        a = 8'd100;
        b = 8'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (mul_en !== 1'b1 || pp_a !== 4'd4 || pp_b !== 4'd6) begin errors++;
            $display("FAIL rmid_pp2 got en=%b pp=%h/%h want 1/4/6", mul_en, pp_a, pp_b); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mul_en !== 1'b0 || pp_a !== 4'h0 || pp_b !== 4'h0) begin errors++;
            $display("FAIL rmid_mul got en=%b pp=%h/%h want 0/0/0", mul_en, pp_a, pp_b); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL rmid_hs got ir=%b ov=%b want 1/0", in_ready, out_valid); end
        checks++; if (product !== 16'h0000 || zero !== 1'b0) begin errors++;
            $display("FAIL rmid_out got p=%h z=%b want 0000/0", product, zero); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL rmid_no_pulse%0d got %b want 0", i, out_valid); end
        end
        run_op(8'd3, 8'd4, lat, p, z);
        checks++; if (lat !== 5 || p !== 16'h000C) begin errors++;
            $display("FAIL rmid_after got lat=%0d p=%h want 5/000c", lat, p); end
    endtask

    task automatic test_reg_sign0();
        int lat;
        @(negedge clk);
        checks++; if (in_ready2 !== 1'b1) begin errors++;
            $display("FAIL ns_ready got %b want 1", in_ready2); end
        a = 8'h07;
        b = 8'hFD;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        a = 8'hC3;
        b = 8'h11;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 4) begin errors++;
            $display("FAIL ns_latency got %0d want 4", lat); end
        checks++; if (product2 !== 16'hFFEB || zero2 !== 1'b0) begin errors++;
            $display("FAIL ns_product got %h z=%b want ffeb/0", product2, zero2); end
        @(posedge clk);
        #1;
        checks++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++;
            $display("FAIL ns_release got ov=%b ir=%b want 0/1", out_valid2, in_ready2); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_reg_sign0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
